// File: rtl/ipf_pkg.sv
// Shared types, constants and helpers for the in-loop post-filter front end.
// Parameter-word layout is common to the LCU feeder and the filter itself.
package ipf_pkg;

   localparam int unsigned IMG_W   = 128;
   localparam int unsigned ADDR_W  = 14;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned COORD_W = 7;
   localparam int unsigned LCU_W   = 3;
   localparam int unsigned PIX_W   = 6;
   localparam int unsigned PIDX_W  = 6;

   localparam logic [1:0] SIZE_16 = 2'd0;
   localparam logic [1:0] SIZE_32 = 2'd1;
   localparam logic [1:0] SIZE_64 = 2'd2;

   localparam int unsigned PARAM_W   = 24;
   localparam int unsigned TYPE_W    = 2;
   localparam int unsigned BAND_W    = 5;
   localparam int unsigned OFFS_W    = 16;
   localparam int unsigned TYPE_LSB  = 22;
   localparam int unsigned BAND_LSB  = 17;
   localparam int unsigned CLASS_BIT = 16;
   localparam int unsigned OFFS_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE, ST_PARAM, ST_PLATCH, ST_STREAM, ST_DRAIN, ST_DONE
   } state_e;

   typedef struct packed {
      logic [TYPE_W-1:0] typ;
      logic [BAND_W-1:0] band_pos;
      logic              wo_class;
      logic [OFFS_W-1:0] offset;
   } param_t;

   function automatic logic [1:0] clamp_size(input logic [1:0] cfg);
      return (cfg == 2'd3) ? SIZE_64 : cfg;
   endfunction

   // Last pixel offset inside an LCU (side - 1).
   function automatic logic [PIX_W-1:0] side_m1(input logic [1:0] size);
      return PIX_W'((16 << size) - 1);
   endfunction

   // Last LCU coordinate along one axis (LCUs per row - 1).
   function automatic logic [LCU_W-1:0] lcus_m1(input logic [1:0] size);
      return LCU_W'((8 >> size) - 1);
   endfunction

   function automatic logic [COORD_W-1:0] lcu_origin(input logic [LCU_W-1:0] lcu,
                                                     input logic [1:0]       size);
      return COORD_W'(32'(lcu) << (4 + size));
   endfunction

   function automatic logic [PIDX_W-1:0] lcu_index(input logic [LCU_W-1:0] ly,
                                                   input logic [LCU_W-1:0] lx,
                                                   input logic [1:0]       size);
      return PIDX_W'((32'(ly) << (3 - size)) + 32'(lx));
   endfunction

endpackage

// File: rtl/lcu_feed_skid.sv
// Two-entry skid FIFO between the frame-buffer read pipe and the filter input.
module lcu_feed_skid
   import ipf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [1:0]        count_o,
   output logic [DATA_W-1:0] head_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(push_i) - 2'(pop_i);
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/lcu_feeder.sv
// Walks the frame buffer LCU by LCU and streams pixels plus per-LCU sideband to the IPF.
// Optional macro LCU_FEEDER_PERF_EN adds the stall_cycles backpressure counter.
module lcu_feeder
   import ipf_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          lcu_size_cfg,
   output logic                mem_rd,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_data,
   output logic                param_rd,
   output logic [PIDX_W-1:0]   param_addr,
   input  logic [PARAM_W-1:0]  param_data,
   input  logic                busy,
   output logic                in_en,
   output logic [DATA_W-1:0]   din,
   output logic [TYPE_W-1:0]   ipf_type,
   output logic [BAND_W-1:0]   ipf_band_pos,
   output logic                ipf_wo_class,
   output logic [OFFS_W-1:0]   ipf_offset,
   output logic [LCU_W-1:0]    lcu_x,
   output logic [LCU_W-1:0]    lcu_y,
   output logic [1:0]          lcu_size,
   output logic                done
`ifdef LCU_FEEDER_PERF_EN
   ,
   output logic [15:0]         stall_cycles
`endif
);

   state_e             state_q;
   logic [1:0]         size_q;
   logic [LCU_W-1:0]   lcu_x_q, lcu_y_q;
   logic [PIX_W-1:0]   px_q, py_q;
   logic               param_rd_q;
   logic [PIDX_W-1:0]  param_addr_q;
   param_t             side_q;
   logic               done_q;
   logic               infl_q;

   logic [1:0]         fifo_count;
   logic               pop_c, issue_c;
   logic [2:0]         occ_c;
   logic               px_last_c, last_pix_c, x_wrap_c, last_lcu_c, drained_c;
   logic [LCU_W-1:0]   nx_c, ny_c;
   logic [COORD_W-1:0] x_c, y_c;

   lcu_feed_skid u_skid (
      .clk     (clk),
      .reset   (reset),
      .push_i  (infl_q),
      .data_i  (mem_data),
      .pop_i   (pop_c),
      .count_o (fifo_count),
      .head_o  (din)
   );

   // Read strobe is combinational so the credit check sees this cycle's pop.
   assign in_en   = (fifo_count != 2'd0);
   assign pop_c   = in_en & ~busy;
   assign occ_c   = 3'(fifo_count) + 3'(infl_q) - 3'(pop_c);
   assign issue_c = (state_q == ST_STREAM) && (occ_c < 3'd2);

   assign px_last_c  = (px_q == side_m1(size_q));
   assign last_pix_c = px_last_c && (py_q == side_m1(size_q));
   assign x_wrap_c   = (lcu_x_q == lcus_m1(size_q));
   assign last_lcu_c = x_wrap_c && (lcu_y_q == lcus_m1(size_q));
   assign nx_c       = x_wrap_c ? '0 : lcu_x_q + LCU_W'(1);
   assign ny_c       = x_wrap_c ? lcu_y_q + LCU_W'(1) : lcu_y_q;
   assign drained_c  = (fifo_count == 2'd0) && !infl_q;

   assign x_c      = lcu_origin(lcu_x_q, size_q) + COORD_W'(px_q);
   assign y_c      = lcu_origin(lcu_y_q, size_q) + COORD_W'(py_q);
   assign mem_rd   = issue_c;
   assign mem_addr = {y_c, x_c};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         size_q       <= 2'd0;
         lcu_x_q      <= '0;
         lcu_y_q      <= '0;
         px_q         <= '0;
         py_q         <= '0;
         param_rd_q   <= 1'b0;
         param_addr_q <= '0;
         side_q       <= '0;
         done_q       <= 1'b0;
         infl_q       <= 1'b0;
      end else begin
         param_rd_q <= 1'b0;
         infl_q     <= issue_c;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  size_q       <= clamp_size(lcu_size_cfg);
                  lcu_x_q      <= '0;
                  lcu_y_q      <= '0;
                  done_q       <= 1'b0;
                  param_rd_q   <= 1'b1;
                  param_addr_q <= '0;
                  state_q      <= ST_PARAM;
               end
            end
            ST_PARAM: state_q <= ST_PLATCH;
            ST_PLATCH: begin
               side_q  <= param_t'(param_data);
               px_q    <= '0;
               py_q    <= '0;
               state_q <= ST_STREAM;
            end
            ST_STREAM: begin
               if (issue_c) begin
                  if (px_last_c) begin
                     px_q <= '0;
                     py_q <= py_q + PIX_W'(1);
                  end else begin
                     px_q <= px_q + PIX_W'(1);
                  end
                  if (last_pix_c) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Hold off the next parameter fetch until every pixel of this LCU has left.
               if (drained_c) begin
                  if (last_lcu_c) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     lcu_x_q      <= nx_c;
                     lcu_y_q      <= ny_c;
                     param_rd_q   <= 1'b1;
                     param_addr_q <= lcu_index(ny_c, nx_c, size_q);
                     state_q      <= ST_PARAM;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign param_rd     = param_rd_q;
   assign param_addr   = param_addr_q;
   assign ipf_type     = side_q.typ;
   assign ipf_band_pos = side_q.band_pos;
   assign ipf_wo_class = side_q.wo_class;
   assign ipf_offset   = side_q.offset;
   assign lcu_x        = lcu_x_q;
   assign lcu_y        = lcu_y_q;
   assign lcu_size     = size_q;
   assign done         = done_q;

`ifdef LCU_FEEDER_PERF_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_q <= 16'd0;
      end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
         stall_q <= 16'd0;
      end else if (in_en && busy && (state_q != ST_DONE) && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_lcu_feeder.sv
// Directed bench for lcu_feeder: frame-buffer/param-table models and an in-order pixel scoreboard.
module tb_lcu_feeder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  lcu_size_cfg;
   logic        mem_rd;
   logic [13:0] mem_addr;
   logic [7:0]  mem_data;
   logic        param_rd;
   logic [5:0]  param_addr;
   logic [23:0] param_data;
   logic        busy;
   logic        in_en;
   logic [7:0]  din;
   logic [1:0]  ipf_type;
   logic [4:0]  ipf_band_pos;
   logic        ipf_wo_class;
   logic [15:0] ipf_offset;
   logic [2:0]  lcu_x, lcu_y;
   logic [1:0]  lcu_size;
   logic        done;
`ifdef LCU_FEEDER_PERF_EN
   logic [15:0] stall_cycles;
`endif

   lcu_feeder dut (
      .clk(clk), .reset(reset), .start(start), .lcu_size_cfg(lcu_size_cfg),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .param_rd(param_rd), .param_addr(param_addr), .param_data(param_data),
      .busy(busy), .in_en(in_en), .din(din),
      .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
      .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size),
      .done(done)
`ifdef LCU_FEEDER_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   typedef struct {
      logic [7:0]  din;
      logic [2:0]  lx;
      logic [2:0]  ly;
      logic [23:0] par;
      bit          first;
   } exp_t;

   logic [7:0]  fb   [16384];
   logic [23:0] ptab [64];
   exp_t        sb [$];
   int          checks;
   int          failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memories answer one cycle after their read strobe.
   always_ff @(posedge clk) begin
      mem_data   <= mem_rd   ? fb[mem_addr]     : 8'hxx;
      param_data <= param_rd ? ptab[param_addr] : 24'hxxxxxx;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {mem_rd, mem_addr, param_rd, param_addr, in_en, din, ipf_type, ipf_band_pos,
              ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
   endfunction

   // Runs one frame (or its first max_xfer pixels); bp adds 5 busy cycles after every 16th transfer.
   task automatic run_frame(input logic [1:0] cfg, input bit bp, input int max_xfer, input int ign_at);
      logic [1:0] sz;
      int   side, n, xfer, cyc, last_cyc, bp_left, ign_phase;
      exp_t e;
      sz   = (cfg == 2'd3) ? 2'd2 : cfg;
      side = 16 << sz;
      n    = 8 >> sz;
      sb.delete();
      for (int ly = 0; ly < n; ly++)
         for (int lx = 0; lx < n; lx++)
            for (int py = 0; py < side; py++)
               for (int px = 0; px < side; px++) begin
                  e.din   = fb[(ly * side + py) * 128 + lx * side + px];
                  e.lx    = 3'(lx);
                  e.ly    = 3'(ly);
                  e.par   = ptab[ly * n + lx];
                  e.first = (px == 0 && py == 0);
                  sb.push_back(e);
               end

      @(posedge clk); #1;
      lcu_size_cfg = cfg;
      start        = 1'b1;
      busy         = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;

      xfer = 0; cyc = 0; last_cyc = 0; bp_left = 0; ign_phase = 0;
      while (sb.size() != 0 && xfer < max_xfer && cyc < 40000) begin
         cyc++;
         @(negedge clk);
         if (in_en && !busy) begin
            e = sb.pop_front();
            chk("pixel", {din, lcu_x, lcu_y, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset},
                {e.din, e.lx, e.ly, e.par});
            if (!bp) begin
               if (xfer == 0)    chk("first_latency", 64'(cyc <= 5), 64'd1);
               else if (e.first) chk("lcu_gap", 64'(cyc - last_cyc <= 6), 64'd1);
               else              chk("back_to_back", 64'(cyc - last_cyc), 64'd1);
            end
            if (sz == 2'd2) begin
               if (xfer == 0)    chk("xfer0",    {din, lcu_x, lcu_y}, {8'd0,  3'd0, 3'd0});
               if (xfer == 4096) chk("xfer4096", {din, lcu_x, lcu_y}, {8'd64, 3'd1, 3'd0});
               if (xfer == 8192) chk("xfer8192", {din, lcu_x, lcu_y}, {8'd64, 3'd0, 3'd1});
            end
            if (sb.size() == 0) chk("done_early", 64'(done), 64'd0);
            last_cyc = cyc;
            xfer++;
            if (bp && (xfer % 16 == 0)) bp_left = 5;
         end
         @(posedge clk); #1;
         busy = (bp_left > 0);
         if (bp_left > 0) bp_left--;
         if (ign_phase == 1) begin
            start        = 1'b0;
            lcu_size_cfg = cfg;
            ign_phase    = 2;
         end else if (ign_phase == 0 && xfer == ign_at) begin
            start        = 1'b1;
            lcu_size_cfg = 2'd0;
            ign_phase    = 1;
         end
      end
      busy  = 1'b0;
      start = 1'b0;
      chk("frame_progress", 64'(sb.size() == 0 || xfer >= max_xfer), 64'd1);

      if (xfer < max_xfer) begin
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) break;
         end
         chk("done", 64'(done), 64'd1);
         chk("lcu_size", 64'(lcu_size), 64'(sz));
`ifdef LCU_FEEDER_PERF_EN
         // The busy burst after an LCU's final pixel finds the skid empty, so it never stalls.
         chk("stall_cycles", 64'(stall_cycles), bp ? 64'(5 * (xfer / 16 - n * n)) : 64'd0);
`endif
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; start = 1'b0; busy = 1'b0; lcu_size_cfg = 2'd0;
      for (int y = 0; y < 128; y++)
         for (int x = 0; x < 128; x++)
            fb[y * 128 + x] = 8'((x + y) & 255);
      for (int k = 0; k < 64; k++)
         ptab[k] = {2'(k % 3), 5'(k % 32), 1'(k % 2), 16'h1234 + 16'(k)};

      repeat (2) @(negedge clk);
      chk("reset_outputs", all_outs(), 64'd0);
`ifdef LCU_FEEDER_PERF_EN
      chk("reset_stall", 64'(stall_cycles), 64'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;

      run_frame(2'd3, 1'b0, 100000, 50);   // clamped size, stray start mid-stream
      run_frame(2'd0, 1'b0, 100000, -1);   // 64 LCUs of sideband
      run_frame(2'd2, 1'b1, 100000, -1);   // periodic backpressure
      run_frame(2'd1, 1'b0, 100000, -1);   // 32x32 throughput

      run_frame(2'd2, 1'b0, 100, -1);
      chk("pre_reset_active", 64'(in_en), 64'd1);
      #2 reset = 1'b1;
      #1 chk("async_reset_outputs", all_outs(), 64'd0);
`ifdef LCU_FEEDER_PERF_EN
      chk("async_reset_stall", 64'(stall_cycles), 64'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;
      run_frame(2'd2, 1'b0, 200, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
